// File: rtl/product_accumulator.sv
// product_accumulator
//   Consumes one signed multiplier product per valid/ready handshake. The
//   product is optionally negated. It is then loaded into, or added to, a
//   64-bit signed accumulator with saturation. The result goes out on the
//   32-bit result bus as two beats: low word, then high word.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : product and control fields valid
//   in_ready   : block can accept a product (IDLE only)
//   in_product : signed product from the multiplier
//   in_acc     : 1 = accumulate into the register, 0 = load
//   in_neg     : 1 = negate the product before the load/accumulate
//   acc_clear  : clears the accumulator and the overflow flag (IDLE only)
//   out_valid  : out_data valid
//   out_ready  : consumer accepts the current beat
//   out_data   : result beat
//   out_last   : high on the high-word beat
//   ovf        : sticky saturation flag
module product_accumulator #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_acc,
  input  logic              in_neg,
  input  logic              acc_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              ovf
);

  // Two guard bits hold base + (+/-product) exactly. This includes the
  // +2^63 that comes from negating the most negative product.
  localparam int unsigned EXT_W = PROD_W + 2;

  typedef enum logic [1:0] {
    StIdle,
    StSendLo,
    StSendHi
  } state_e;

  state_e             state_q, state_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic [EXT_W-1:0]   prod_ext, term_ext, base_ext, sum_ext;
  logic               pos_sat, neg_sat, sat_hit;
  logic [PROD_W-1:0]  sat_val;
  logic               accept;

  // Full-precision datapath
  always_comb begin
    prod_ext = {{2{in_product[PROD_W-1]}}, in_product};
    term_ext = in_neg ? (~prod_ext + EXT_W'(1)) : prod_ext;
    base_ext = (in_acc && !acc_clear) ? {{2{acc_q[PROD_W-1]}}, acc_q} : '0;
    sum_ext  = base_ext + term_ext;
    // The sum is in range only when the top three bits agree.
    pos_sat  = !sum_ext[EXT_W-1] && (sum_ext[EXT_W-2:PROD_W-1] != 2'b00);
    neg_sat  = sum_ext[EXT_W-1] && (sum_ext[EXT_W-2:PROD_W-1] != 2'b11);
    sat_hit  = pos_sat | neg_sat;
    if (pos_sat) begin
      sat_val = {1'b0, {(PROD_W-1){1'b1}}};
    end else if (neg_sat) begin
      sat_val = {1'b1, {(PROD_W-1){1'b0}}};
    end else begin
      sat_val = sum_ext[PROD_W-1:0];
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d      = sat_val;
          // acc_clear on the same cycle restarts ovf before this operation.
          ovf_d      = (ovf_q & ~acc_clear) | sat_hit;
          out_data_d = sat_val[OUT_W-1:0];
          out_last_d = 1'b0;
          state_d    = StSendLo;
        end else if (acc_clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
      end
      StSendLo: begin
        if (out_ready) begin
          out_data_d = acc_q[PROD_W-1:OUT_W];
          out_last_d = 1'b1;
          state_d    = StSendHi;
        end
      end
      StSendHi: begin
        // out_data keeps the high word after the last beat.
        if (out_ready) begin
          out_last_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_product;
  logic        in_acc;
  logic        in_neg;
  logic        acc_clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] lo, hi;
  logic        lo_last, hi_last, lo_v, hi_v;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(64), .OUT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_acc     (in_acc),
    .in_neg     (in_neg),
    .acc_clear  (acc_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .ovf        (ovf)
  );

  // Drives one full transaction with out_ready held high. Starts from IDLE
  // and returns at the negedge where the block is back in IDLE.
  task automatic run_op(input logic [63:0] prod, input logic accf, input logic neg,
                        input logic clr);
    @(negedge clk);
    in_product = prod; in_acc = accf; in_neg = neg; acc_clear = clr;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; acc_clear = 1'b0;
    lo = out_data; lo_last = out_last; lo_v = out_valid;
    @(negedge clk);
    hi = out_data; hi_last = out_last; hi_v = out_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_product = '0; in_acc = 1'b0; in_neg = 1'b0;
    acc_clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin
      $display("FAIL rst_in_ready_during got=%b exp=0", in_ready); n_fail++; end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin
      $display("FAIL rst_out_valid got=%b exp=0", out_valid); n_fail++; end
    n_checks++; if (out_last !== 1'b0) begin
      $display("FAIL rst_out_last got=%b exp=0", out_last); n_fail++; end
    n_checks++; if (out_data !== 32'h0) begin
      $display("FAIL rst_out_data got=%h exp=0", out_data); n_fail++; end
    n_checks++; if (ovf !== 1'b0) begin
      $display("FAIL rst_ovf got=%b exp=0", ovf); n_fail++; end
    n_checks++; if (in_ready !== 1'b1) begin
      $display("FAIL rst_in_ready got=%b exp=1", in_ready); n_fail++; end
  endtask

  task automatic test_load();
    run_op(64'h6, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({lo_v, lo_last, lo} !== {1'b1, 1'b0, 32'h6}) begin
      $display("FAIL load_lo got=%b/%b/%h exp=1/0/00000006", lo_v, lo_last, lo); n_fail++; end
    n_checks++; if ({hi_v, hi_last, hi} !== {1'b1, 1'b1, 32'h0}) begin
      $display("FAIL load_hi got=%b/%b/%h exp=1/1/00000000", hi_v, hi_last, hi); n_fail++; end
    n_checks++; if ({in_ready, out_valid, out_last} !== 3'b100) begin
      $display("FAIL load_idle got=%b exp=100", {in_ready, out_valid, out_last}); n_fail++; end
    n_checks++; if (ovf !== 1'b0) begin
      $display("FAIL load_ovf got=%b exp=0", ovf); n_fail++; end
  endtask

  task automatic test_accumulate();
    run_op(64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({lo, hi} !== {32'hFFFF_FFF7, 32'hFFFF_FFFF}) begin
      $display("FAIL acc_add got=%h/%h exp=fffffff7/ffffffff", lo, hi); n_fail++; end
    run_op(64'h9, 1'b1, 1'b1, 1'b0);
    n_checks++; if ({lo, hi} !== {32'hFFFF_FFEE, 32'hFFFF_FFFF}) begin
      $display("FAIL acc_sub got=%h/%h exp=ffffffee/ffffffff", lo, hi); n_fail++; end
    n_checks++; if (ovf !== 1'b0) begin
      $display("FAIL acc_ovf got=%b exp=0", ovf); n_fail++; end
  endtask

  task automatic test_saturation();
    run_op(64'h7FFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0);
    run_op(64'h20, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({lo, hi, ovf} !== {32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1}) begin
      $display("FAIL sat_pos got=%h/%h ovf=%b exp=ffffffff/7fffffff ovf=1", lo, hi, ovf);
      n_fail++; end
    run_op(64'h5, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({lo, hi, ovf} !== {32'h5, 32'h0, 1'b1}) begin
      $display("FAIL sat_sticky got=%h/%h ovf=%b exp=00000005/00000000 ovf=1", lo, hi, ovf);
      n_fail++; end
    @(negedge clk); acc_clear = 1'b1;
    @(negedge clk); acc_clear = 1'b0;
    n_checks++; if ({ovf, in_ready, out_valid} !== 3'b010) begin
      $display("FAIL sat_clear got=%b exp=010", {ovf, in_ready, out_valid}); n_fail++; end
    run_op(64'h3, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({lo, hi} !== {32'h3, 32'h0}) begin
      $display("FAIL sat_after_clear got=%h/%h exp=00000003/00000000", lo, hi); n_fail++; end
  endtask

  task automatic test_negation();
    run_op(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    n_checks++; if ({lo, hi, ovf} !== {32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1}) begin
      $display("FAIL neg_min_load got=%h/%h ovf=%b exp=ffffffff/7fffffff ovf=1", lo, hi, ovf);
      n_fail++; end
    // Load -1 with acc_clear so ovf restarts at 0.
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    n_checks++; if ({lo, hi, ovf} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0}) begin
      $display("FAIL neg_load_m1 got=%h/%h ovf=%b exp=ffffffff/ffffffff ovf=0", lo, hi, ovf);
      n_fail++; end
    run_op(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    n_checks++; if ({lo, hi, ovf} !== {32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0}) begin
      $display("FAIL neg_min_acc got=%h/%h ovf=%b exp=ffffffff/7fffffff ovf=0", lo, hi, ovf);
      n_fail++; end
    // -(-2^63) + -2^63 = 0: the sum is in range, so no saturation.
    run_op(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    run_op(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    n_checks++; if ({lo, hi, ovf} !== {32'h0, 32'h0, 1'b0}) begin
      $display("FAIL neg_min_cancel got=%h/%h ovf=%b exp=0/0 ovf=0", lo, hi, ovf); n_fail++; end
  endtask

  task automatic test_backpressure();
    run_op(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);  // sets ovf
    @(negedge clk);
    in_product = 64'h0000_0001_2345_6789; in_acc = 1'b0; in_neg = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_product = 64'h0000_0000_0000_0055; acc_clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, out_last, out_data, in_ready, ovf} !== {2'b10, 32'h2345_6789, 2'b01}) begin
        $display("FAIL bp_hold[%0d] got v=%b l=%b d=%h rdy=%b ovf=%b exp v=1 l=0 d=23456789 rdy=0 ovf=1",
                 i, out_valid, out_last, out_data, in_ready, ovf);
        n_fail++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h1}) begin
      $display("FAIL bp_hi got v=%b l=%b d=%h exp v=1 l=1 d=00000001", out_valid, out_last, out_data);
      n_fail++; end
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready, ovf} !== 3'b011) begin
      $display("FAIL bp_idle got=%b exp=011", {out_valid, in_ready, ovf}); n_fail++; end
    run_op(64'h1, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({lo, hi} !== {32'h2345_678A, 32'h1}) begin
      $display("FAIL bp_acc_kept got=%h/%h exp=2345678a/00000001", lo, hi); n_fail++; end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_product = 64'h0000_0002_0000_0003; in_acc = 1'b0; in_neg = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h2}) begin
      $display("FAIL rm_in_hi got v=%b l=%b d=%h exp v=1 l=1 d=00000002", out_valid, out_last, out_data);
      n_fail++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, out_data, in_ready, ovf} !== {2'b00, 32'h0, 2'b10}) begin
      $display("FAIL rm_after got v=%b l=%b d=%h rdy=%b ovf=%b exp v=0 l=0 d=0 rdy=1 ovf=0",
               out_valid, out_last, out_data, in_ready, ovf);
      n_fail++;
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin
      $display("FAIL rm_no_beat got=%b exp=0", out_valid); n_fail++; end
    run_op(64'h7, 1'b1, 1'b0, 1'b0);  // acc was reset, so 0 + 7
    n_checks++; if ({lo, hi} !== {32'h7, 32'h0}) begin
      $display("FAIL rm_acc_zero got=%h/%h exp=00000007/00000000", lo, hi); n_fail++; end
    run_op(64'h7, 1'b1, 1'b0, 1'b1);  // clear wins over in_acc
    n_checks++; if ({lo, hi, ovf} !== {32'h7, 32'h0, 1'b0}) begin
      $display("FAIL rm_clear_acc got=%h/%h ovf=%b exp=00000007/00000000 ovf=0", lo, hi, ovf);
      n_fail++; end
  endtask

  initial begin
    test_reset();
    test_load();
    test_accumulate();
    test_saturation();
    test_negation();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 32x32 signed multiplier's 64-bit two's-complement product.
- Takes one product per valid/ready handshake and loads or accumulates it into a 64-bit signed register. Accumulation is add or subtract, with saturation.
- Returns the result on the 32-bit ALU result bus as two beats: low word, then high word.
- Provides multiply-accumulate and 64-bit result writeback for the ALU.

Parameters:
- PROD_W, 64, product and accumulator width; signed two's complement.
- OUT_W, 32, result bus width. PROD_W must equal 2*OUT_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product and control fields valid.
- in_ready  output  1  block can accept a product.
- in_product  input  PROD_W  signed product from the multiplier.
- in_acc  input  1  1 = accumulate into register; 0 = load (start from zero).
- in_neg  input  1  1 = negate the product before the load/accumulate.
- acc_clear  input  1  clears accumulator and overflow flag.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  OUT_W  result beat.
- out_last  output  1  high on the high-word beat.
- ovf  output  1  sticky saturation flag.

Behaviour:
- Synchronous reset: state IDLE, acc=0, ovf=0, out_valid=0, out_data=0, out_last=0. in_ready=1 in the cycle after reset.
- Reset has priority over every other input in every state. Reset mid-transfer abandons the transfer; no further beats are emitted.
- FSM states: IDLE, SEND_LO, SEND_HI.
- in_ready = (state==IDLE) && !rst. It is high only in IDLE.
- IDLE, acc_clear=1 without in_valid: acc<=0, ovf<=0; remain in IDLE.
- IDLE, accept when in_valid && in_ready. With p = in_neg ? -in_product : in_product:
  - base = (in_acc && !acc_clear) ? acc : 0.
  - acc <= sat(base + p), computed at full precision (PROD_W+2 bits).
  - If acc_clear is also asserted, ovf restarts from 0 before this operation.
  - Next state is SEND_LO.
- Negation rule: -(0x8000_0000_0000_0000) is carried at full precision (+2^63). It saturates only if the final sum exceeds the 64-bit range.
- Saturation:
  - sum > 2^63-1 gives 0x7FFF_FFFF_FFFF_FFFF.
  - sum < -2^63 gives 0x8000_0000_0000_0000.
  - Either case sets ovf<=1. ovf is sticky and cleared only by rst or acc_clear.
- Latency: product accepted at edge N; out_valid=1, out_data=acc[31:0], out_last=0 from edge N until the next handshake.
- SEND_LO: on out_valid && out_ready, go to SEND_HI with out_data=acc[63:32] and out_last=1.
- SEND_HI: on handshake, go to IDLE with out_valid=0 and out_last=0. out_data holds its last value.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable.
- acc_clear and in_valid are ignored outside IDLE. The accumulator is not modified during a transfer.
- Throughput: at most one product per 3 cycles when out_ready is held high.
- ovf updates in the same edge as acc.

Test Plan:
- Reset, then load 0x0000_0000_0000_0006 (in_acc=0, in_neg=0) with out_ready=1 -> accept at N, beats 0x00000006 (last=0) then 0x00000000 (last=1), in_ready back high after 3 cycles, ovf=0.
- With acc=6, accumulate 0xFFFF_FFFF_FFFF_FFF1 (-15) -> beats 0xFFFFFFF7, 0xFFFFFFFF. Then accumulate 0x0000_0000_0000_0009 with in_neg=1 -> acc=-18, beats 0xFFFFFFEE, 0xFFFFFFFF.
- Saturation: load 0x7FFF_FFFF_FFFF_FFF0, then accumulate 0x20 -> 0xFFFFFFFF, 0x7FFFFFFF, ovf=1. Load 5 -> beats 5/0, ovf still 1. acc_clear pulse in IDLE -> ovf=0; next accumulate of 3 yields 3.
- Negation edge cases:
  - Load 0x8000_0000_0000_0000 with in_neg=1 -> 0x7FFF_FFFF_FFFF_FFFF, ovf=1.
  - acc=-1, accumulate 0x8000_0000_0000_0000 with in_neg=1 -> exactly 0x7FFF_FFFF_FFFF_FFFF, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in SEND_LO while driving in_valid=1 and acc_clear=1 -> out_data constant, in_ready=0, acc and ovf unchanged. Release -> normal two beats.
- Assert rst in SEND_HI -> next cycle out_valid=0, out_last=0, out_data=0, in_ready=1, acc=0, ovf=0. Check simultaneous acc_clear+in_valid (in_acc=1, product 7) -> result 7.
